// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, address-width helper and default types for the register file
package regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_DEPTH = 32;
    function automatic int aw_of(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
    localparam int DEF_AW = aw_of(DEF_DEPTH);
    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xlen_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero register, write-first bypass and ready flag
module regfile_read_port import regfile_pkg::*; #(
    parameter int XLEN     = DEF_XLEN,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int AW      = aw_of(DEPTH)
) (
    input  logic [DEPTH-1:0][XLEN-1:0] i_regs,
    input  logic [DEPTH-1:0]           i_pending,
    input  logic [AW-1:0]              i_addr,
    input  logic                       i_wb_en,
    input  logic [AW-1:0]              i_wb_rd,
    input  logic [XLEN-1:0]            i_wb_data,
    output logic [XLEN-1:0]            o_data,
    output logic                       o_ready
);
    logic w_zero, w_byp;
    always_comb begin
        w_zero  = (ZERO_REG != 0) && (i_addr == '0);
        w_byp   = i_wb_en && (i_wb_rd == i_addr);
        o_data  = w_zero ? '0 : w_byp ? i_wb_data : i_regs[i_addr];
        o_ready = w_zero || w_byp || !i_pending[i_addr];
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write-first bypass and a pending-destination scoreboard
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int XLEN      = DEF_XLEN,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int ALLOW_WAW = 0,
    localparam int AW       = aw_of(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   i_rs_addr,
    output logic [NUM_RD*XLEN-1:0] o_rs_data,
    output logic [NUM_RD-1:0]      o_rs_ready,
    input  logic                   i_issue_valid,
    input  logic [AW-1:0]          i_issue_rd,
    output logic                   o_issue_stall,
    input  logic                   i_wb_en,
    input  logic [AW-1:0]          i_wb_rd,
    input  logic [XLEN-1:0]        i_wb_data,
    input  logic                   i_flush,
    output logic [AW:0]            o_busy_count
);
    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);
    logic [DEPTH-1:0][XLEN-1:0] r_regs;
    logic [DEPTH-1:0]           r_pending;
    logic [AW:0]                r_busy;
    logic                       w_wb_en, w_wb_hit, w_iss_zero, w_accept, w_inc, w_dec;
    logic [DEPTH-1:0]           w_set, w_clr;
    always_comb begin
        // bypass is suppressed in reset so reads show the cleared storage
        w_wb_en       = i_wb_en && !rst;
        w_wb_hit      = i_wb_en && (i_wb_rd == i_issue_rd);
        w_iss_zero    = (ZERO_REG != 0) && (i_issue_rd == '0);
        o_issue_stall = i_issue_valid && (ALLOW_WAW == 0) && r_pending[i_issue_rd] && !w_wb_hit && !w_iss_zero;
        w_accept      = i_issue_valid && !o_issue_stall && !w_iss_zero && !i_flush;
        w_set         = w_accept ? ONE << i_issue_rd : '0;
        w_clr         = i_wb_en ? ONE << i_wb_rd : '0;
        w_inc         = w_accept && !r_pending[i_issue_rd];
        w_dec         = i_wb_en && r_pending[i_wb_rd] && !w_set[i_wb_rd];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs    <= '0;
            r_pending <= '0;
            r_busy    <= '0;
        end else begin
            if (i_wb_en && !((ZERO_REG != 0) && (i_wb_rd == '0)))
                r_regs[i_wb_rd] <= i_wb_data;
            r_pending <= i_flush ? '0 : (r_pending & ~w_clr) | w_set;
            r_busy    <= i_flush ? '0 : r_busy + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end
    assign o_busy_count = r_busy;
    genvar g;
    for (g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_read_port #(.XLEN(XLEN), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd (
            .i_regs   (r_regs),
            .i_pending(r_pending),
            .i_addr   (i_rs_addr[g*AW +: AW]),
            .i_wb_en  (w_wb_en),
            .i_wb_rd  (i_wb_rd),
            .i_wb_data(i_wb_data),
            .o_data   (o_rs_data[g*XLEN +: XLEN]),
            .o_ready  (o_rs_ready[g])
        );
    end
endmodule
